// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: three one-entry holding slots (ALU, load, base
// writeback) share the register-file write port. A round-robin arbiter
// retires one slot per cycle into registered rf_en/rf_sel/rf_data, and a
// same-register interlock keeps at most one pending write per index so
// writes to one register retire in acceptance order.
module regfile_write_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          req_valid,
    output logic [2:0]          req_ready,
    input  logic [11:0]         req_reg,
    input  logic [3*DATA_W-1:0] req_data,
    input  logic                hold,
    output logic                rf_en,
    output logic [3:0]          rf_sel,
    output logic [DATA_W-1:0]   rf_data,
    output logic                pc_wr,
    output logic                busy
);

    logic [2:0]        full_q, full_d;
    logic [3:0]        slot_reg_q  [3];
    logic [3:0]        slot_reg_d  [3];
    logic [DATA_W-1:0] slot_data_q [3];
    logic [DATA_W-1:0] slot_data_d [3];
    logic [1:0]        ptr_q, ptr_d;
    logic              rf_en_q, rf_en_d;
    logic [3:0]        rf_sel_q, rf_sel_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic              pc_wr_q, pc_wr_d;

    logic [2:0]        grant;
    logic [1:0]        grant_idx;
    logic              grant_any;
    logic [1:0]        scan_idx;
    logic [2:0]        slot_hit;
    logic [2:0]        ready_base;
    logic [2:0]        tie_hit;
    logic [2:0]        accept;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    // Round-robin pick of the first full slot starting at ptr; none while held.
    always_comb begin
        grant     = 3'b000;
        grant_idx = 2'd0;
        grant_any = 1'b0;
        scan_idx  = 2'd0;
        for (int k = 0; k < 3; k++) begin
            scan_idx = wrap3({1'b0, ptr_q} + 3'(k));
            if (!hold && !grant_any && full_q[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
                grant_any       = 1'b1;
            end
        end
    end

    // Slot availability, blocked when the index is still pending in another slot.
    always_comb begin
        slot_hit   = 3'b000;
        ready_base = 3'b000;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (j != i && full_q[j] && !grant[j] &&
                    slot_reg_q[j] == req_reg[4*i +: 4]) begin
                    slot_hit[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            ready_base[i] = (~full_q[i] | grant[i]) & ~slot_hit[i];
        end
    end

    // Same-cycle, same-register requests: the lowest port index wins.
    always_comb begin
        tie_hit = 3'b000;
        for (int i = 1; i < 3; i++) begin
            for (int j = 0; j < i; j++) begin
                if (req_valid[j] && ready_base[j] &&
                    req_reg[4*j +: 4] == req_reg[4*i +: 4]) begin
                    tie_hit[i] = 1'b1;
                end
            end
        end
        req_ready = ready_base & ~tie_hit;
        accept    = req_valid & req_ready;
    end

    // Next state: refill beats retire on the same slot; write port updates on grant.
    always_comb begin
        full_d      = full_q;
        slot_reg_d  = slot_reg_q;
        slot_data_d = slot_data_q;
        for (int i = 0; i < 3; i++) begin
            if (accept[i]) begin
                full_d[i]      = 1'b1;
                slot_reg_d[i]  = req_reg[4*i +: 4];
                slot_data_d[i] = req_data[DATA_W*i +: DATA_W];
            end else if (grant[i]) begin
                full_d[i] = 1'b0;
            end
        end
        rf_en_d   = grant_any;
        pc_wr_d   = grant_any && (slot_reg_q[grant_idx] == 4'hF);
        rf_sel_d  = grant_any ? slot_reg_q[grant_idx]  : rf_sel_q;
        rf_data_d = grant_any ? slot_data_q[grant_idx] : rf_data_q;
        ptr_d     = grant_any ? wrap3({1'b0, grant_idx} + 3'd1) : ptr_q;
    end

    // State registers; reset drops pending slots and clears the write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q    <= 3'b000;
            ptr_q     <= 2'd0;
            rf_en_q   <= 1'b0;
            rf_sel_q  <= 4'd0;
            rf_data_q <= '0;
            pc_wr_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                slot_reg_q[i]  <= 4'd0;
                slot_data_q[i] <= '0;
            end
        end else begin
            full_q      <= full_d;
            ptr_q       <= ptr_d;
            rf_en_q     <= rf_en_d;
            rf_sel_q    <= rf_sel_d;
            rf_data_q   <= rf_data_d;
            pc_wr_q     <= pc_wr_d;
            slot_reg_q  <= slot_reg_d;
            slot_data_q <= slot_data_d;
        end
    end

    assign rf_en   = rf_en_q;
    assign rf_sel  = rf_sel_q;
    assign rf_data = rf_data_q;
    assign pc_wr   = pc_wr_q;
    assign busy    = (|full_q) | rf_en_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, reset corner case,
// then randomized producers against a rule-level model and a per-register
// write-order scoreboard.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [11:0] req_reg;
    logic [95:0] req_data;
    logic        hold;
    logic        rf_en;
    logic [3:0]  rf_sel;
    logic [31:0] rf_data;
    logic        pc_wr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_reg(req_reg), .req_data(req_data), .hold(hold), .rf_en(rf_en),
        .rf_sel(rf_sel), .rf_data(rf_data), .pc_wr(pc_wr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  v;
        logic [11:0] regs;
        logic [95:0] data;
        logic        h;
        logic [2:0]  rdy;
        logic        bsy;
        logic        en;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        pc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [2:0] v, input logic [3:0] r2, input logic [3:0] r1,
                                input logic [3:0] r0, input logic [31:0] d2, input logic [31:0] d1,
                                input logic [31:0] d0, input logic h, input logic [2:0] rdy,
                                input logic bsy, input logic en, input logic [3:0] sel,
                                input logic [31:0] dat, input logic pc);
        vec_t e;
        e.v = v; e.regs = {r2, r1, r0}; e.data = {d2, d1, d0}; e.h = h;
        e.rdy = rdy; e.bsy = bsy; e.en = en; e.sel = sel; e.dat = dat; e.pc = pc;
        vecs.push_back(e);
    endfunction

    // ---------------- reference model ----------------
    bit   [2:0]  m_full;
    logic [3:0]  m_reg  [3];
    logic [31:0] m_data [3];
    int          m_ptr;
    logic        m_en, m_pc;
    logic [3:0]  m_sel;
    logic [31:0] m_dat;

    typedef struct { logic [3:0] r; logic [31:0] d; } wr_t;
    wr_t sb[$];

    bit   [2:0]  p_pend;
    logic [3:0]  p_reg  [3];
    logic [31:0] p_data [3];

    function automatic int m_pick();
        if (hold) return -1;
        for (int k = 0; k < 3; k++) begin
            if (m_full[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 3'b000; m_ptr = 0; m_en = 1'b0; m_pc = 1'b0; m_sel = 4'd0; m_dat = 32'd0;
        sb.delete();
        p_pend = 3'b000;
        for (int i = 0; i < 3; i++) begin
            m_reg[i] = 4'd0; m_data[i] = 32'd0; p_reg[i] = 4'd0; p_data[i] = 32'd0;
        end
    endtask

    task automatic rcycle(input int n);
        int          g;
        int          found;
        logic [2:0]  r;
        bit   [15:0] locked;
        bit   [15:0] claimed;
        bit          base;
        #1;
        g = m_pick();
        locked = '0;
        for (int s = 0; s < 3; s++) if (m_full[s] && s != g) locked[m_reg[s]] = 1'b1;
        claimed = '0;
        r = 3'b000;
        for (int i = 0; i < 3; i++) begin
            base = (!m_full[i] || i == g) && !locked[p_reg[i]];
            r[i] = base && !claimed[p_reg[i]];
            if (p_pend[i] && base) claimed[p_reg[i]] = 1'b1;
        end
        chk("rnd_ready", n, 64'(req_ready), 64'(r));
        chk("rnd_busy", n, 64'(busy), 64'((m_full != 3'b000) || m_en));
        @(posedge clk);
        if (g >= 0) begin
            m_en = 1'b1; m_sel = m_reg[g]; m_dat = m_data[g]; m_pc = (m_reg[g] == 4'hF);
            m_full[g] = 1'b0; m_ptr = (g + 1) % 3;
        end else begin
            m_en = 1'b0; m_pc = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (p_pend[i] && r[i]) begin
                m_full[i] = 1'b1; m_reg[i] = p_reg[i]; m_data[i] = p_data[i];
                sb.push_back('{r: p_reg[i], d: p_data[i]});
                p_pend[i] = 1'b0;
            end
        end
        #1;
        chk("rnd_rf_en", n, 64'(rf_en), 64'(m_en));
        chk("rnd_rf_sel", n, 64'(rf_sel), 64'(m_sel));
        chk("rnd_rf_data", n, 64'(rf_data), 64'(m_dat));
        chk("rnd_pc_wr", n, 64'(pc_wr), 64'(m_pc));
        if (rf_en) begin
            found = -1;
            for (int k = 0; k < sb.size(); k++) begin
                if (sb[k].r == rf_sel) begin found = k; break; end
            end
            chk("sb_present", n, 64'(found >= 0), 64'(1));
            if (found >= 0) begin
                chk("sb_order", n, 64'(rf_data), 64'(sb[found].d));
                sb.delete(found);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; req_valid = 3'b000; req_reg = 12'd0; req_data = 96'd0; hold = 1'b0;
        model_reset();

        // 3-port round (ptr=0), refill round, r5 interlock, hold, PC write, single write
        add(3'b111, 4'h4, 4'h2, 4'h1, 32'h44, 32'h22, 32'h11, 0, 3'b111, 0, 0, 4'h0, 32'h0,  0);
        add(3'b001, 4'h4, 4'h2, 4'h8, 32'h44, 32'h22, 32'h80, 0, 3'b001, 1, 1, 4'h1, 32'h11, 0);
        add(3'b010, 4'h4, 4'h9, 4'h8, 32'h44, 32'h90, 32'h80, 0, 3'b010, 1, 1, 4'h2, 32'h22, 0);
        add(3'b100, 4'hA, 4'h9, 4'h8, 32'hA0, 32'h90, 32'h80, 0, 3'b100, 1, 1, 4'h4, 32'h44, 0);
        add(3'b000, 4'hA, 4'h9, 4'h8, 32'hA0, 32'h90, 32'h80, 0, 3'b001, 1, 1, 4'h8, 32'h80, 0);
        add(3'b000, 4'hA, 4'h9, 4'h8, 32'hA0, 32'h90, 32'h80, 0, 3'b011, 1, 1, 4'h9, 32'h90, 0);
        add(3'b000, 4'hA, 4'h9, 4'h8, 32'hA0, 32'h90, 32'h80, 0, 3'b111, 1, 1, 4'hA, 32'hA0, 0);
        add(3'b000, 4'hA, 4'h9, 4'h8, 32'hA0, 32'h90, 32'h80, 0, 3'b111, 1, 0, 4'hA, 32'hA0, 0);
        add(3'b011, 4'h6, 4'h5, 4'h5, 32'h0,  32'h1,  32'h0,  0, 3'b101, 0, 0, 4'hA, 32'hA0, 0);
        add(3'b010, 4'h6, 4'h5, 4'h5, 32'h0,  32'h1,  32'h0,  0, 3'b111, 1, 1, 4'h5, 32'h0,  0);
        add(3'b000, 4'h6, 4'h5, 4'h5, 32'h0,  32'h1,  32'h0,  0, 3'b111, 1, 1, 4'h5, 32'h1,  0);
        add(3'b000, 4'h6, 4'h5, 4'h5, 32'h0,  32'h1,  32'h0,  0, 3'b111, 1, 0, 4'h5, 32'h1,  0);
        add(3'b100, 4'h7, 4'h5, 4'h5, 32'h77, 32'h1,  32'h0,  0, 3'b111, 0, 0, 4'h5, 32'h1,  0);
        for (int k = 0; k < 4; k++)
            add(3'b000, 4'h7, 4'h5, 4'h5, 32'h77, 32'h1, 32'h0, 1, 3'b011, 1, 0, 4'h5, 32'h1, 0);
        add(3'b000, 4'h7, 4'h5, 4'h5, 32'h77, 32'h1,  32'h0,  0, 3'b111, 1, 1, 4'h7, 32'h77, 0);
        add(3'b000, 4'h7, 4'h5, 4'h5, 32'h77, 32'h1,  32'h0,  0, 3'b111, 1, 0, 4'h7, 32'h77, 0);
        add(3'b010, 4'h7, 4'hF, 4'h5, 32'h77, 32'h1000, 32'h0, 0, 3'b111, 0, 0, 4'h7, 32'h77, 0);
        add(3'b000, 4'h7, 4'hF, 4'h5, 32'h77, 32'h1000, 32'h0, 0, 3'b111, 1, 1, 4'hF, 32'h1000, 1);
        add(3'b000, 4'h7, 4'hF, 4'h5, 32'h77, 32'h1000, 32'h0, 0, 3'b111, 1, 0, 4'hF, 32'h1000, 0);
        add(3'b001, 4'h7, 4'hF, 4'h3, 32'h77, 32'h1000, 32'hAA, 0, 3'b111, 0, 0, 4'hF, 32'h1000, 0);
        add(3'b000, 4'h7, 4'hF, 4'h3, 32'h77, 32'h1000, 32'hAA, 0, 3'b111, 1, 1, 4'h3, 32'hAA, 0);
        add(3'b000, 4'h7, 4'hF, 4'h3, 32'h77, 32'h1000, 32'hAA, 0, 3'b111, 1, 0, 4'h3, 32'hAA, 0);
        add(3'b000, 4'h7, 4'hF, 4'h3, 32'h77, 32'h1000, 32'hAA, 0, 3'b111, 0, 0, 4'h3, 32'hAA, 0);

        repeat (2) @(negedge clk);
        chk("rst_rf_en", 0, 64'(rf_en), 64'(0));
        chk("rst_busy", 0, 64'(busy), 64'(0));
        chk("rst_ready", 0, 64'(req_ready), 64'(3'b111));
        reset = 1'b0;
        @(negedge clk);

        for (int n = 0; n < vecs.size(); n++) begin
            req_valid = vecs[n].v; req_reg = vecs[n].regs; req_data = vecs[n].data; hold = vecs[n].h;
            #1;
            chk("tbl_ready", n, 64'(req_ready), 64'(vecs[n].rdy));
            chk("tbl_busy", n, 64'(busy), 64'(vecs[n].bsy));
            @(posedge clk);
            #1;
            chk("tbl_rf_en", n, 64'(rf_en), 64'(vecs[n].en));
            chk("tbl_rf_sel", n, 64'(rf_sel), 64'(vecs[n].sel));
            chk("tbl_rf_data", n, 64'(rf_data), 64'(vecs[n].dat));
            chk("tbl_pc_wr", n, 64'(pc_wr), 64'(vecs[n].pc));
            @(negedge clk);
        end

        // Fill all slots, retire one, then pulse reset between edges.
        req_valid = 3'b111; req_reg = {4'h3, 4'h2, 4'h1}; req_data = {32'h33, 32'h22, 32'h11}; hold = 1'b0;
        @(negedge clk);
        req_valid = 3'b000;
        @(posedge clk);
        #3;
        chk("pre_rst_rf_en", 0, 64'(rf_en), 64'(1));
        reset = 1'b1;
        #1;
        chk("mid_rst_rf_en", 0, 64'(rf_en), 64'(0));
        chk("mid_rst_rf_sel", 0, 64'(rf_sel), 64'(0));
        chk("mid_rst_rf_data", 0, 64'(rf_data), 64'(0));
        chk("mid_rst_pc_wr", 0, 64'(pc_wr), 64'(0));
        chk("mid_rst_busy", 0, 64'(busy), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 0, 64'(req_ready), 64'(3'b111));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_write", k, 64'(rf_en), 64'(0));
        end

        // Randomized producers against the model.
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!p_pend[i] && $urandom_range(0, 1) == 1) begin
                    p_pend[i] = 1'b1;
                    p_reg[i]  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
                    p_data[i] = $urandom;
                end
            end
            req_valid = p_pend;
            req_reg   = {p_reg[2], p_reg[1], p_reg[0]};
            req_data  = {p_data[2], p_data[1], p_data[0]};
            hold      = ($urandom_range(0, 7) == 0);
            rcycle(n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
